// File: rtl/sysbus_mem_responder_pkg.sv
// Shared Sysbus definitions: tag field layout, target/direction codes and
// the state types used by the memory-side responder.
package sysbus_mem_responder_pkg;

  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic       SYSBUS_WRITE  = 1'b0;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

  localparam int unsigned SYSBUS_DIR_BIT = 12;
  localparam int unsigned SYSBUS_TGT_HI  = 11;
  localparam int unsigned SYSBUS_TGT_LO  = 8;

  localparam int unsigned BEATS_PER_LINE = 8;
  localparam int unsigned LINE_BYTES     = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND
  } resp_state_e;

  typedef enum logic {
    ING_REQ,
    ING_WRDATA
  } ing_state_e;

endpackage

// File: rtl/sysbus_mem_responder_req_fifo.sv
// Synchronous FIFO of pending read requests ({line index, tag}); a push into
// a full FIFO is honoured when a pop happens in the same cycle.
module sysbus_req_fifo
  import sysbus_mem_responder_pkg::*;
#(
  parameter int DATA_W = 26,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] slots [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = slots[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= din;
  end

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory-side responder: accepts line reads/writes against an on-chip
// word array and returns each read line as 8 beats paced by bus_respack.
module sysbus_mem_responder
  import sysbus_mem_responder_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 65536,
  parameter int REQ_DEPTH      = 4,
  parameter int LATENCY        = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int AW     = $clog2(MEM_WORDS);
  localparam int BEAT_W = $clog2(BEATS_PER_LINE);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int LW     = AW - BEAT_W;
  localparam int FW     = LW + BUS_TAG_WIDTH;
  localparam int CW     = $clog2(LATENCY + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);

  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

  ing_state_e          ing_state;
  logic [LW-1:0]       wr_line;
  logic [BEAT_W-1:0]   wr_beat;
  resp_state_e         state;
  logic [CW-1:0]       wait_cnt;
  logic [BEAT_W-1:0]   beat;
  logic [LW-1:0]       rd_line;

  logic                is_mem;
  logic                is_read;
  logic                req_slot;
  logic                push;
  logic                pop;
  logic                wr_ok;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FW-1:0]       fifo_dout;
  logic [AW-1:0]       waddr;
  logic [AW-1:0]       raddr;

  always_comb begin
    is_mem   = (bus_reqtag[SYSBUS_TGT_HI:SYSBUS_TGT_LO] == SYSBUS_MEMORY);
    is_read  = (bus_reqtag[SYSBUS_DIR_BIT] == SYSBUS_READ);
    req_slot = bus_reqcyc && (ing_state == ING_REQ);
    pop      = !fifo_empty &&
               ((state == IDLE) ||
                ((state == SEND) && bus_respack && (beat == LAST_BEAT)));
    push     = req_slot && is_mem && is_read && (!fifo_full || pop);
    // Writes wait for every earlier read to drain so none can overtake them.
    wr_ok    = req_slot && is_mem && !is_read && fifo_empty && (state == IDLE);
    waddr    = {wr_line, wr_beat};
    raddr    = {rd_line, beat};
  end

  sysbus_req_fifo #(
    .DATA_W (FW),
    .DEPTH  (REQ_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({bus_req[OFF_W+LW-1:OFF_W], bus_reqtag}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_reqack <= 1'b0;
      ing_state  <= ING_REQ;
      wr_line    <= '0;
      wr_beat    <= '0;
    end else begin
      bus_reqack <= 1'b0;
      unique case (ing_state)
        ING_REQ: begin
          // Non-memory targets are acknowledged and dropped.
          if (req_slot && (!is_mem || push || wr_ok)) bus_reqack <= 1'b1;
          if (wr_ok) begin
            ing_state <= ING_WRDATA;
            wr_line   <= bus_req[OFF_W+LW-1:OFF_W];
            wr_beat   <= '0;
          end
        end
        ING_WRDATA: begin
          if (bus_reqcyc) begin
            bus_reqack <= 1'b1;
            wr_beat    <= wr_beat + 1'b1;
            if (wr_beat == LAST_BEAT) ing_state <= ING_REQ;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && (ing_state == ING_WRDATA) && bus_reqcyc) mem[waddr] <= bus_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      beat        <= '0;
      rd_line     <= '0;
      bus_resptag <= '0;
      bus_respcyc <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            {rd_line, bus_resptag} <= fifo_dout;
            wait_cnt <= CW'(LATENCY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state       <= SEND;
            beat        <= '0;
            bus_respcyc <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        SEND: begin
          if (bus_respack) begin
            if (beat == LAST_BEAT) begin
              bus_respcyc <= 1'b0;
              if (pop) begin
                {rd_line, bus_resptag} <= fifo_dout;
                wait_cnt <= CW'(LATENCY - 1);
                state    <= WAIT;
              end else begin
                state <= IDLE;
              end
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_resp = bus_respcyc ? mem[raddr] : '0;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder: requests push expected beats,
// a negedge monitor pops and compares every beat the responder presents.
module tb_sysbus_mem_responder;

  localparam int LATENCY   = 8;
  localparam int MEM_WORDS = 65536;
  localparam logic [12:0] RD_TAG = 13'h1100;
  localparam logic [12:0] WR_TAG = 13'h0100;
  localparam logic [12:0] IO_TAG = 13'h1305;
  localparam logic [63:0] PBASE  = 64'h1000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_reqcyc = 1'b0;
  logic [63:0] bus_req = '0;
  logic [12:0] bus_reqtag = '0;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack = 1'b0;

  always #5 clk = ~clk;

  sysbus_mem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .LATENCY   (LATENCY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [12:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ack_mode = 0;   // 0 always, 1 alternate, 2 budgeted
  int   ack_budget = 0;
  int   mon_beat = 0;
  int   cur_len  = 0;
  int   last_len = 0;
  int   idle_run = 0;
  logic prev_cyc = 1'b0;
  logic last_ack = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Initiator-side respack generator.
  initial begin
    forever begin
      @(negedge clk);
      last_ack = bus_respcyc && bus_respack;
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       bus_respack = 1'b1;
        1:       bus_respack = !last_ack;
        2:       bus_respack = (ack_budget > 0);
        default: bus_respack = 1'b0;
      endcase
    end
  end

  // Monitor: compare each presented beat against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (bus_respcyc === 1'b1) begin
        if (!prev_cyc) check("burst_gap_ge_latency", 64'(idle_run >= LATENCY), 64'd1);
        cur_len++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got data %h tag %h, expected no beat", bus_resp, bus_resptag);
        end else begin
          check("resp_data", bus_resp, exp_q[0].data);
          check("resp_tag", 64'(bus_resptag), 64'(exp_q[0].tag));
          if (bus_respack === 1'b1) begin
            void'(exp_q.pop_front());
            if (ack_mode == 2 && ack_budget > 0) ack_budget--;
            mon_beat = (mon_beat + 1) % 8;
            if (mon_beat == 0) begin
              last_len = cur_len;
              cur_len  = 0;
            end
          end
        end
        idle_run = 0;
        prev_cyc = 1'b1;
      end else begin
        idle_run++;
        prev_cyc = 1'b0;
      end
    end
  end

  task automatic send_item(input logic [63:0] d, input logic [12:0] t,
                           input int max_wait, output int waited);
    bus_reqcyc = 1'b1;
    bus_req    = d;
    bus_reqtag = t;
    waited     = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (bus_reqack !== 1'b1 && waited < max_wait);
  endtask

  task automatic push_line(input logic [63:0] base, input logic [12:0] t);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.data = base + 64'(i);
      e.tag  = t;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [63:0] base,
                         input logic [7:0] id, input int max_wait, output int waited);
    send_item(addr, RD_TAG | 13'(id), max_wait, waited);
    bus_reqcyc = 1'b0;
    check("rd_req_acked", 64'(bus_reqack), 64'd1);
    if (bus_reqack === 1'b1) push_line(base, RD_TAG | 13'(id));
  endtask

  task automatic write_line(input logic [63:0] addr, input logic [63:0] base,
                            input int max_wait, output int req_wait, output int q_at_ack);
    int w;
    int total;
    send_item(addr, WR_TAG, max_wait, req_wait);
    q_at_ack = exp_q.size();
    check("wr_req_acked", 64'(bus_reqack), 64'd1);
    total = 0;
    for (int i = 0; i < 8; i++) begin
      send_item(base + 64'(i), WR_TAG, 4, w);
      total += w;
    end
    bus_reqcyc = 1'b0;
    check("wr_beat_cycles", 64'(total), 64'd8);
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus_respcyc === 1'b1) && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tagname);
    check({tagname, "_reqack"}, 64'(bus_reqack), 64'd0);
    check({tagname, "_respcyc"}, 64'(bus_respcyc), 64'd0);
    check({tagname, "_resp"}, bus_resp, 64'd0);
    check({tagname, "_resptag"}, 64'(bus_resptag), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int q;
    int n;
    int cnt;

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;

    // Preload lines 0..7 with PBASE + 8*line + beat.
    for (int l = 0; l < 8; l++) begin
      write_line(64'(l * 64), PBASE + 64'(8 * l), 4, w, q);
      check("wr_req_latency", 64'(w), 64'd1);
    end

    // Plain read of line 1 at full ack rate, with first-beat latency.
    ack_mode = 0;
    do_read(64'h40, PBASE + 64'd8, 8'd1, 4, w);
    check("rd_req_latency", 64'(w), 64'd1);
    n = 0;
    while (bus_respcyc !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("first_beat_latency", 64'(n), 64'(LATENCY + 1));
    drain(200);
    check("burst_len_full_rate", 64'(last_len), 64'd8);

    // Alternating respack: each beat held until acked.
    ack_mode = 1;
    do_read(64'h40, PBASE + 64'd8, 8'd2, 4, w);
    drain(300);
    check("burst_len_alternate", 64'(last_len), 64'd15);

    // Back-to-back reads with respack held low. One entry sits in the read
    // FSM and four in the FIFO, so the sixth read is the first to stall.
    ack_mode = 2;
    ack_budget = 0;
    for (int l = 1; l <= 5; l++) begin
      do_read(64'(l * 64), PBASE + 64'(8 * l), 8'(16 + l), 4, w);
      check("b2b_rd_latency", 64'(w), 64'd1);
    end
    send_item(64'(6 * 64), RD_TAG | 13'd22, 20, w);
    check("sixth_read_stalled", 64'(bus_reqack), 64'd0);
    ack_mode = 0;
    send_item(64'(6 * 64), RD_TAG | 13'd22, 60, w);
    check("sixth_read_acked", 64'(bus_reqack), 64'd1);
    check("queue_at_sixth_ack", 64'(exp_q.size()), 64'd32);
    bus_reqcyc = 1'b0;
    push_line(PBASE + 64'd48, RD_TAG | 13'd22);
    drain(600);

    // Non-memory target: acked and dropped, no response.
    send_item(64'h40, IO_TAG, 4, w);
    bus_reqcyc = 1'b0;
    check("io_dropped_ack", 64'(w), 64'd1);
    repeat (20) @(posedge clk);
    #1;

    // Write line 2 then read it back.
    write_line(64'h80, 64'hA0, 4, w, q);
    check("wr80_req_latency", 64'(w), 64'd1);
    do_read(64'h80, 64'hA0, 8'd3, 4, w);
    drain(200);

    // Write while a read is pending waits for that burst to drain.
    do_read(64'hC0, PBASE + 64'd24, 8'd4, 4, w);
    write_line(64'h180, 64'hB0, 100, w, q);
    check("wr_stalled_behind_read", 64'(w > LATENCY), 64'd1);
    check("rd_drained_before_wr", 64'(q), 64'd0);
    do_read(64'h180, 64'hB0, 8'd5, 4, w);
    drain(200);

    // Reset while beat 3 is held, with a second read still queued.
    ack_mode = 2;
    ack_budget = 3;
    do_read(64'h40, PBASE + 64'd8, 8'd6, 4, w);
    do_read(64'hC0, PBASE + 64'd24, 8'd7, 4, w);
    n = 0;
    while (!(mon_beat == 3 && bus_respcyc === 1'b1) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_beat3", 64'(mon_beat), 64'd3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    mon_beat = 0;
    cur_len  = 0;
    ack_mode = 0;
    check_idle_outputs("midburst_reset");
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus_respcyc === 1'b1) cnt++;
    end
    check("no_resp_after_reset", 64'(cnt), 64'd0);
    do_read(64'hC0, PBASE + 64'd24, 8'd8, 4, w);
    drain(200);

    // Unaligned address and wrapped address both map to line 1.
    do_read(64'h7F, PBASE + 64'd8, 8'd9, 4, w);
    do_read(64'(MEM_WORDS) * 64'd8 + 64'h40, PBASE + 64'd8, 8'd10, 4, w);
    drain(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
